// File: rtl/matrix_pkg.sv
// matrix_pkg
//   Shared definitions for the matrix compiler write path.
//   - Default geometry and the widths derived from it (row, column, element).
//   - TOTAL_ELEMS: number of distinct addresses that make up one frame.
//   - state_t: frame state of the write arbiter.
//   - Helper functions so parameterised modules derive the same widths
//     from their own MAX_SIZE_A / MAX_SIZE_B overrides.
package matrix_pkg;

    localparam int MAX_ELEMENT_SIZE_DEF = 8;
    localparam int MAX_SIZE_A_DEF       = 32;
    localparam int MAX_SIZE_B_DEF       = 32;
    localparam int NUM_REQ_DEF          = 4;

    localparam int ROW_W       = $clog2(MAX_SIZE_A_DEF);
    localparam int COL_W       = $clog2(MAX_SIZE_B_DEF);
    localparam int ELEM_W      = MAX_ELEMENT_SIZE_DEF;
    localparam int TOTAL_ELEMS = MAX_SIZE_A_DEF * MAX_SIZE_B_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    function automatic int total_elems(input int size_a, input int size_b);
        return size_a * size_b;
    endfunction

    // elem_count must be able to hold the value TOTAL_ELEMS itself.
    function automatic int count_width(input int size_a, input int size_b);
        return $clog2(size_a * size_b) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Generic round-robin arbiter with a registered priority pointer.
//   Ports:
//     inter_refclk  clock
//     rst           synchronous active-high reset (pointer -> NUM_REQ-1)
//     req           per-requester request
//     update_en     a grant was taken this cycle; pointer moves to the winner
//     grant         one-hot-or-zero grant, searched from pointer+1 upward
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               inter_refclk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update_en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] win_idx;

    // Scan NUM_REQ positions starting just after the last winner; the first
    // requester found wins, so the last winner has the lowest priority.
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant   = '0;
        win_idx = ptr_reg;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr_reg) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            ptr_reg <= PW'(NUM_REQ - 1);
        end else if (update_en) begin
            ptr_reg <= win_idx;
        end
    end

endmodule

// File: rtl/matrix_write_arbiter.sv
// matrix_write_arbiter
//   Shares the compiler's single element-write port between NUM_REQ lanes,
//   tracks which addresses of the current frame have been written, and holds
//   all lanes off while the compiler transmits a completed frame.
//   Ports:
//     inter_refclk, rst        clock, synchronous active-high reset
//     req_valid/row/col/data   per-lane offers (packed, lane i at [i*W +: W])
//     req_ready                one-hot-or-zero accept back to the lanes
//     compiler_busy            compiler is transmitting a frame
//     valid_data_out, row_addr, col_addr, matrix_element   write bus
//     elem_count               distinct elements accepted this frame
//     frame_done               pulse with the final element's write strobe
//     dup_error                pulse when a repeated address was dropped
module matrix_write_arbiter
    import matrix_pkg::*;
#(
    parameter int MAX_ELEMENT_SIZE = MAX_ELEMENT_SIZE_DEF,
    parameter int MAX_SIZE_A       = MAX_SIZE_A_DEF,
    parameter int MAX_SIZE_B       = MAX_SIZE_B_DEF,
    parameter int NUM_REQ          = NUM_REQ_DEF,
    localparam int RW   = $clog2(MAX_SIZE_A),
    localparam int CW   = $clog2(MAX_SIZE_B),
    localparam int TOT  = total_elems(MAX_SIZE_A, MAX_SIZE_B),
    localparam int CNTW = count_width(MAX_SIZE_A, MAX_SIZE_B)
) (
    input  logic                          inter_refclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*RW-1:0]         req_row,
    input  logic [NUM_REQ*CW-1:0]         req_col,
    input  logic [NUM_REQ*MAX_ELEMENT_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          compiler_busy,
    output logic                          valid_data_out,
    output logic [RW-1:0]                 row_addr,
    output logic [CW-1:0]                 col_addr,
    output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
    output logic [CNTW-1:0]               elem_count,
    output logic                          frame_done,
    output logic                          dup_error
);

    state_t state_reg, state_next;

    logic [RW-1:0]               lane_row  [NUM_REQ];
    logic [CW-1:0]               lane_col  [NUM_REQ];
    logic [MAX_ELEMENT_SIZE-1:0] lane_data [NUM_REQ];

    logic [NUM_REQ-1:0]          grant;
    logic                        grant_ok;
    logic                        accept;
    logic [RW-1:0]               sel_row;
    logic [CW-1:0]               sel_col;
    logic [MAX_ELEMENT_SIZE-1:0] sel_data;
    logic [RW+CW-1:0]            sel_addr;
    logic                        is_dup;
    logic                        is_new;
    logic                        completes;
    logic                        frame_clear;

    // Written-address bitmap. Kept in flops rather than RAM: the duplicate
    // check must be answered in the accept cycle and the whole map is wiped
    // in one cycle when the frame is released.
    logic [TOT-1:0]              tracker_reg;
    logic [CNTW-1:0]             count_reg;

    logic                        valid_reg;
    logic [RW-1:0]               row_reg;
    logic [CW-1:0]               col_reg;
    logic [MAX_ELEMENT_SIZE-1:0] data_reg;
    logic                        done_reg;
    logic                        dup_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_row[gi]  = req_row[gi*RW +: RW];
        assign lane_col[gi]  = req_col[gi*CW +: CW];
        assign lane_data[gi] = req_data[gi*MAX_ELEMENT_SIZE +: MAX_ELEMENT_SIZE];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .inter_refclk (inter_refclk),
        .rst          (rst),
        .req          (req_valid),
        .update_en    (accept),
        .grant        (grant)
    );

    assign req_ready = grant & {NUM_REQ{grant_ok}};
    assign accept    = |req_ready;

    // Grant is one-hot, so a plain priority mux selects the winning lane.
    always_comb begin
        sel_row  = '0;
        sel_col  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_row  = lane_row[i];
                sel_col  = lane_col[i];
                sel_data = lane_data[i];
            end
        end
    end

    // Both dimensions are powers of two, so row*B+col is a concatenation.
    assign sel_addr    = {sel_row, sel_col};
    assign is_dup      = tracker_reg[sel_addr];
    assign is_new      = accept && !is_dup;
    assign completes   = is_new && (count_reg == CNTW'(TOT - 1));
    assign frame_clear = (state_reg == WAIT_LO) && !compiler_busy;

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_ok   = 1'b0;
        case (state_reg)
            IDLE: begin
                // A new frame may not start while the previous one is still
                // being transmitted.
                grant_ok = !compiler_busy;
                if (completes)   state_next = WAIT_HI;
                else if (accept) state_next = COLLECT;
            end
            COLLECT: begin
                grant_ok = 1'b1;
                if (completes) state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (compiler_busy) state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!compiler_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            tracker_reg <= '0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
            row_reg     <= '0;
            col_reg     <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            dup_reg     <= 1'b0;
        end else begin
            valid_reg <= is_new;
            dup_reg   <= accept && is_dup;
            done_reg  <= completes;
            if (frame_clear) begin
                tracker_reg <= '0;
                count_reg   <= '0;
            end else if (is_new) begin
                tracker_reg[sel_addr] <= 1'b1;
                count_reg             <= count_reg + CNTW'(1);
            end
            // Duplicates are consumed but leave the bus holding the last write.
            if (is_new) begin
                row_reg  <= sel_row;
                col_reg  <= sel_col;
                data_reg <= sel_data;
            end
        end
    end

    assign valid_data_out = valid_reg;
    assign row_addr       = row_reg;
    assign col_addr       = col_reg;
    assign matrix_element = data_reg;
    assign elem_count     = count_reg;
    assign frame_done     = done_reg;
    assign dup_error      = dup_reg;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
module tb_matrix_write_arbiter;

    localparam int A    = 4;
    localparam int B    = 4;
    localparam int N    = 3;
    localparam int E    = 8;
    localparam int RW   = 2;
    localparam int CW   = 2;
    localparam int TOT  = 16;
    localparam int CNTW = 5;

    logic              inter_refclk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*RW-1:0]   req_row;
    logic [N*CW-1:0]   req_col;
    logic [N*E-1:0]    req_data;
    logic [N-1:0]      req_ready;
    logic              compiler_busy;
    logic              valid_data_out;
    logic [RW-1:0]     row_addr;
    logic [CW-1:0]     col_addr;
    logic [E-1:0]      matrix_element;
    logic [CNTW-1:0]   elem_count;
    logic              frame_done;
    logic              dup_error;

    always #5 inter_refclk = ~inter_refclk;

    matrix_write_arbiter #(
        .MAX_ELEMENT_SIZE (E),
        .MAX_SIZE_A       (A),
        .MAX_SIZE_B       (B),
        .NUM_REQ          (N)
    ) dut (
        .inter_refclk   (inter_refclk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_row        (req_row),
        .req_col        (req_col),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .compiler_busy  (compiler_busy),
        .valid_data_out (valid_data_out),
        .row_addr       (row_addr),
        .col_addr       (col_addr),
        .matrix_element (matrix_element),
        .elem_count     (elem_count),
        .frame_done     (frame_done),
        .dup_error      (dup_error)
    );

    typedef struct {
        int due;
        bit dup;
        int row;
        int col;
        int data;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Reference model: frame contents as a set of written addresses, plus
    // "frame full / compiler has started / compiler finished" flags.
    bit   written[TOT];
    int   count;
    int   last_lane;
    bit   started;
    bit   full;
    bit   seen_busy;
    int   last_row, last_col, last_dat;

    // Lane offers and control inputs chosen by the scenarios.
    bit   lane_v[N];
    int   lane_row[N], lane_col[N], lane_dat[N];
    bit   busy_v, rst_v;
    int   pool[$];
    int   acc;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < TOT; i++) written[i] = 1'b0;
        count = 0; started = 0; full = 0; seen_busy = 0;
    endtask

    task automatic model_reset();
        clear_frame();
        last_lane = N - 1;
        last_row = 0; last_col = 0; last_dat = 0;
    endtask

    // One clock cycle: drive inputs, check req_ready against the model,
    // then advance the model across the coming edge.
    task automatic step(output int acc_o);
        logic [N-1:0] exp_rdy;
        bit           permit, was_full;
        int           li, addr;
        exp_t         ne;
        @(negedge inter_refclk);
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = rst_v ? 1'b0 : lane_v[i];
            req_row[i*RW +: RW]   = RW'(lane_row[i]);
            req_col[i*CW +: CW]   = CW'(lane_col[i]);
            req_data[i*E +: E]    = E'(lane_dat[i]);
        end
        compiler_busy = busy_v;
        rst           = rst_v;
        #1;
        acc_o   = -1;
        exp_rdy = '0;
        permit  = !rst_v && !full && (started || !busy_v);
        if (permit) begin
            for (int k = 1; k <= N; k++) begin
                li = (last_lane + k) % N;
                if (acc_o < 0 && lane_v[li]) acc_o = li;
            end
        end
        if (acc_o >= 0) exp_rdy[acc_o] = 1'b1;
        check("req_ready", int'(req_ready), int'(exp_rdy));
        if (rst_v) begin
            model_reset();
            acc_o = -1;
        end else begin
            was_full = full;
            if (acc_o >= 0) begin
                addr      = lane_row[acc_o] * B + lane_col[acc_o];
                last_lane = acc_o;
                started   = 1;
                ne.due  = cyc + 1;
                ne.row  = lane_row[acc_o];
                ne.col  = lane_col[acc_o];
                ne.data = lane_dat[acc_o];
                ne.dup  = written[addr];
                ne.done = 1'b0;
                if (!ne.dup) begin
                    written[addr] = 1'b1;
                    count++;
                    ne.done = (count == TOT);
                    if (ne.done) full = 1;
                end
                sb.push_back(ne);
            end
            if (was_full) begin
                if (!seen_busy) begin
                    if (busy_v) seen_busy = 1;
                end else if (!busy_v) begin
                    clear_frame();
                end
            end
        end
    endtask

    task automatic offer(input int li, input int r, input int c);
        lane_v[li]   = 1'b1;
        lane_row[li] = r;
        lane_col[li] = c;
        lane_dat[li] = int'($urandom_range(0, 255));
    endtask

    task automatic new_offer(input int li);
        int a;
        if (pool.size() > 0) begin
            a = pool.pop_front();
            offer(li, a / B, a % B);
        end else begin
            lane_v[li] = 1'b0;
        end
    endtask

    task automatic fill_unwritten_shuffled();
        int j, t;
        pool.delete();
        for (int i = 0; i < TOT; i++) if (!written[i]) pool.push_back(i);
        for (int i = pool.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
    endtask

    task automatic run_lane_until_taken(input int li);
        int a;
        for (int t = 0; t < 8 && lane_v[li]; t++) begin
            step(a);
            if (a == li) lane_v[li] = 1'b0;
        end
    endtask

    task automatic lanes_off();
        for (int i = 0; i < N; i++) lane_v[i] = 1'b0;
    endtask

    // Monitor: samples registered outputs 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge inter_refclk);
            #1;
            cyc++;
            if (mon_en) begin
                check("elem_count", int'(elem_count), count);
                if (valid_data_out || dup_error) begin
                    if (sb.size() == 0 || sb[0].due != cyc) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_output cyc=%0d got valid=%0b dup=%0b expected no output",
                                 cyc, valid_data_out, dup_error);
                    end else begin
                        e = sb.pop_front();
                        check("valid_data_out", int'(valid_data_out), int'(!e.dup));
                        check("dup_error", int'(dup_error), int'(e.dup));
                        check("frame_done", int'(frame_done), int'(e.done && !e.dup));
                        if (!e.dup) begin
                            check("row_addr", int'(row_addr), e.row);
                            check("col_addr", int'(col_addr), e.col);
                            check("matrix_element", int'(matrix_element), e.data);
                            last_row = e.row; last_col = e.col; last_dat = e.data;
                        end
                    end
                end else begin
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        e = sb.pop_front();
                        n_cmp++; n_fail++;
                        $display("FAIL missing_output cyc=%0d got valid=0 dup=0 expected dup=%0b row=%0d col=%0d",
                                 cyc, e.dup, e.row, e.col);
                    end
                    check("frame_done_idle", int'(frame_done), 0);
                end
                if (!valid_data_out) begin
                    check("row_hold", int'(row_addr), last_row);
                    check("col_hold", int'(col_addr), last_col);
                    check("data_hold", int'(matrix_element), last_dat);
                end
            end
        end
    end

    initial begin
        req_valid = '0; req_row = '0; req_col = '0; req_data = '0;
        compiler_busy = 1'b0; rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            lane_v[i] = 0; lane_row[i] = 0; lane_col[i] = 0; lane_dat[i] = 0;
        end
        busy_v = 0; rst_v = 1;
        model_reset();
        step(acc); step(acc);
        mon_en = 1'b1;
        step(acc);
        rst_v = 0;

        // All three lanes valid with distinct addresses: strict 0,1,2 rotation.
        pool.delete();
        for (int i = 0; i < TOT; i++) pool.push_back(i);
        fill_unwritten_shuffled();
        for (int i = 0; i < N; i++) new_offer(i);
        for (int t = 0; t < 40 && !full; t++) begin
            step(acc);
            if (acc >= 0) new_offer(acc);
        end
        $display("frame 1 collected, count=%0d", count);

        // Release: busy low 5, high 10, then low; lane 0 waits with (0,0).
        lanes_off();
        offer(0, 0, 0);
        busy_v = 0; repeat (5) step(acc);
        busy_v = 1; repeat (10) step(acc);
        busy_v = 0;
        run_lane_until_taken(0);
        $display("frame released, new frame started with (0,0)");

        // Same address twice from lane 1: second copy is dropped.
        offer(1, 2, 1); run_lane_until_taken(1);
        offer(1, 2, 1); run_lane_until_taken(1);
        $display("duplicate (2,1) offered");

        // Complete the frame with busy toggling (ignored while collecting).
        fill_unwritten_shuffled();
        for (int i = 0; i < N; i++) new_offer(i);
        for (int t = 0; t < 40 && !full; t++) begin
            busy_v = started ? bit'($urandom_range(0, 1)) : 1'b0;
            step(acc);
            if (acc >= 0) new_offer(acc);
        end
        lanes_off();

        // Single-cycle busy pulse must still release the frame.
        busy_v = 0; repeat (2) step(acc);
        busy_v = 1; step(acc);
        busy_v = 0;
        for (int t = 0; t < 6 && full; t++) step(acc);
        $display("frame 2 released by one-cycle busy pulse");

        // Busy in IDLE blocks lane 0 until it falls.
        offer(0, 1, 1);
        busy_v = 1; repeat (4) step(acc);
        busy_v = 0;
        run_lane_until_taken(0);
        $display("idle busy hold-off done");

        // Reset mid-frame at count 7; address 7 is among the written ones.
        fill_unwritten_shuffled();
        for (int i = 0; i < pool.size(); i++) if (pool[i] == 7) pool.delete(i);
        pool.push_front(7);
        for (int i = 0; i < N; i++) new_offer(i);
        for (int t = 0; t < 30 && count < 7; t++) begin
            step(acc);
            if (acc >= 0) new_offer(acc);
        end
        lanes_off();
        rst_v = 1; step(acc); rst_v = 0;
        offer(0, 1, 3);
        run_lane_until_taken(0);
        $display("reset at count 7, address 7 re-sent");

        // Fresh frame: lane 2 alone, addresses 0..15 in order, back to back.
        rst_v = 1; step(acc); rst_v = 0;
        pool.delete();
        for (int i = 0; i < TOT; i++) pool.push_back(i);
        new_offer(2);
        for (int t = 0; t < 40 && !full; t++) begin
            busy_v = started ? bit'($urandom_range(0, 1)) : 1'b0;
            step(acc);
            if (acc == 2) new_offer(2);
        end
        offer(2, 0, 0);
        busy_v = 0; repeat (3) step(acc);
        busy_v = 1; step(acc);
        busy_v = 0;
        run_lane_until_taken(2);
        $display("single-lane frame done");

        // Random traffic: any address (duplicates likely), random busy, rare reset.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++)
                if (!lane_v[i] && $urandom_range(0, 1) == 1)
                    offer(i, int'($urandom_range(0, A - 1)), int'($urandom_range(0, B - 1)));
            busy_v = ($urandom_range(0, 9) < 3);
            rst_v  = ($urandom_range(0, 99) == 0);
            step(acc);
            if (acc >= 0) lane_v[acc] = 1'b0;
        end
        rst_v = 0; busy_v = 0;
        lanes_off();
        repeat (3) step(acc);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
